// File: rtl/exu_csr.sv
// Machine-mode CSR execute stage: CSR read/modify/write, ecall/mret traps and
// the free-running mcycle counter, with a one-entry valid/ready output register.
module exu_csr #(
  parameter int unsigned          CPU_WIDTH = 64,
  parameter logic [CPU_WIDTH-1:0] MTVEC_RST = CPU_WIDTH'(64'h8000_0000)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [11:0]          i_csrid,
  input  logic                 i_csrsren,
  input  logic                 i_csrdwen,
  input  logic [1:0]           i_excsropt,
  input  logic                 i_excsrsrc,
  input  logic [CPU_WIDTH-1:0] i_rs1val,
  input  logic [CPU_WIDTH-1:0] i_imm,
  input  logic [4:0]           i_rdid,
  input  logic                 i_rdwen,
  input  logic                 i_ecall,
  input  logic                 i_mret,
  input  logic [CPU_WIDTH-1:0] i_pc,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [4:0]           o_rdid,
  output logic                 o_rdwen,
  output logic [CPU_WIDTH-1:0] o_rdwdata,
  output logic                 o_redirect,
  output logic [CPU_WIDTH-1:0] o_redirect_pc,
  output logic                 o_illegal
);

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;

  localparam logic [CPU_WIDTH-1:0] ALIGN_MASK    = ~CPU_WIDTH'(3);
  localparam logic [CPU_WIDTH-1:0] CAUSE_ECALL_M = CPU_WIDTH'(11);

  logic                 valid_q, valid_d;
  logic [4:0]           rdid_q, rdid_d;
  logic                 rdwen_q, rdwen_d;
  logic [CPU_WIDTH-1:0] rdwdata_q, rdwdata_d;
  logic                 redirect_q, redirect_d;
  logic [CPU_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
  logic                 illegal_q, illegal_d;

  logic                 mie_q, mie_d, mpie_q, mpie_d;
  logic [CPU_WIDTH-1:0] mtvec_q, mtvec_d;
  logic [CPU_WIDTH-1:0] mscratch_q, mscratch_d;
  logic [CPU_WIDTH-1:0] mepc_q, mepc_d;
  logic [CPU_WIDTH-1:0] mcause_q, mcause_d;
  logic [CPU_WIDTH-1:0] mcycle_q, mcycle_d;

  logic                 accept;
  logic                 csr_hit, csr_illegal, csr_wen;
  logic [CPU_WIDTH-1:0] mstatus_rd, csr_old, csr_src, csr_new;

  assign o_ready = ~valid_q | i_ready;
  assign accept  = i_valid & o_ready;

  // mstatus view: MPP fixed to M-mode, only MIE/MPIE are state
  always_comb begin
    mstatus_rd        = '0;
    mstatus_rd[12:11] = 2'b11;
    mstatus_rd[7]     = mpie_q;
    mstatus_rd[3]     = mie_q;
  end

  // Address decode, pre-write read value and read-modify-write result
  always_comb begin
    csr_hit = 1'b1;
    csr_old = '0;
    case (i_csrid)
      CSR_MSTATUS:  csr_old = mstatus_rd;
      CSR_MTVEC:    csr_old = mtvec_q;
      CSR_MSCRATCH: csr_old = mscratch_q;
      CSR_MEPC:     csr_old = mepc_q;
      CSR_MCAUSE:   csr_old = mcause_q;
      CSR_MCYCLE:   csr_old = mcycle_q;
      default:      csr_hit = 1'b0;
    endcase
    csr_src = i_excsrsrc ? i_imm : i_rs1val;
    case (i_excsropt)
      2'b01:   csr_new = csr_src;
      2'b10:   csr_new = csr_old | csr_src;
      2'b11:   csr_new = csr_old & ~csr_src;
      default: csr_new = csr_old;
    endcase
    csr_illegal = (i_csrsren | i_csrdwen) & ~csr_hit;
    csr_wen     = accept & i_csrdwen & (|i_excsropt) & csr_hit & ~i_ecall & ~i_mret;
  end

  always_comb begin
    valid_d       = valid_q;
    rdid_d        = rdid_q;
    rdwen_d       = rdwen_q;
    rdwdata_d     = rdwdata_q;
    redirect_d    = redirect_q;
    redirect_pc_d = redirect_pc_q;
    illegal_d     = illegal_q;
    mie_d         = mie_q;
    mpie_d        = mpie_q;
    mtvec_d       = mtvec_q;
    mscratch_d    = mscratch_q;
    mepc_d        = mepc_q;
    mcause_d      = mcause_q;
    mcycle_d      = mcycle_q + CPU_WIDTH'(1);

    if (accept) begin
      valid_d       = 1'b1;
      rdid_d        = i_rdid;
      rdwen_d       = i_rdwen & ~csr_illegal;
      rdwdata_d     = (i_csrsren & csr_hit) ? csr_old : '0;
      illegal_d     = csr_illegal;
      redirect_d    = i_ecall | i_mret;
      redirect_pc_d = '0;
      if (i_ecall) begin
        redirect_pc_d = mtvec_q;
        mepc_d        = i_pc & ALIGN_MASK;
        mcause_d      = CAUSE_ECALL_M;
        mpie_d        = mie_q;
        mie_d         = 1'b0;
      end else if (i_mret) begin
        redirect_pc_d = mepc_q;
        mie_d         = mpie_q;
        mpie_d        = 1'b1;
      end
    end else if (valid_q & i_ready) begin
      valid_d       = 1'b0;
      redirect_d    = 1'b0;
      redirect_pc_d = '0;
      illegal_d     = 1'b0;
    end

    // A software write to mcycle replaces this cycle's increment
    if (csr_wen) begin
      case (i_csrid)
        CSR_MSTATUS: begin
          mie_d  = csr_new[3];
          mpie_d = csr_new[7];
        end
        CSR_MTVEC:    mtvec_d    = csr_new & ALIGN_MASK;
        CSR_MSCRATCH: mscratch_d = csr_new;
        CSR_MEPC:     mepc_d     = csr_new & ALIGN_MASK;
        CSR_MCAUSE:   mcause_d   = csr_new;
        CSR_MCYCLE:   mcycle_d   = csr_new;
        default:      ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q       <= 1'b0;
      rdid_q        <= '0;
      rdwen_q       <= 1'b0;
      rdwdata_q     <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      illegal_q     <= 1'b0;
      mie_q         <= 1'b0;
      mpie_q        <= 1'b0;
      mtvec_q       <= MTVEC_RST;
      mscratch_q    <= '0;
      mepc_q        <= '0;
      mcause_q      <= '0;
      mcycle_q      <= '0;
    end else begin
      valid_q       <= valid_d;
      rdid_q        <= rdid_d;
      rdwen_q       <= rdwen_d;
      rdwdata_q     <= rdwdata_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      illegal_q     <= illegal_d;
      mie_q         <= mie_d;
      mpie_q        <= mpie_d;
      mtvec_q       <= mtvec_d;
      mscratch_q    <= mscratch_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      mcycle_q      <= mcycle_d;
    end
  end

  assign o_valid       = valid_q;
  assign o_rdid        = rdid_q;
  assign o_rdwen       = rdwen_q;
  assign o_rdwdata     = rdwdata_q;
  assign o_redirect    = redirect_q;
  assign o_redirect_pc = redirect_pc_q;
  assign o_illegal     = illegal_q;

endmodule

// File: tb/tb_exu_csr.sv
// Bench for exu_csr: directed scenarios then random traffic, all checked
// against a CSR-file reference model.
module tb_exu_csr;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [11:0] i_csrid = '0;
  logic        i_csrsren = 1'b0, i_csrdwen = 1'b0;
  logic [1:0]  i_excsropt = '0;
  logic        i_excsrsrc = 1'b0;
  logic [63:0] i_rs1val = '0, i_imm = '0;
  logic [4:0]  i_rdid = '0;
  logic        i_rdwen = 1'b0;
  logic        i_ecall = 1'b0, i_mret = 1'b0;
  logic [63:0] i_pc = '0;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic [4:0]  o_rdid;
  logic        o_rdwen;
  logic [63:0] o_rdwdata;
  logic        o_redirect;
  logic [63:0] o_redirect_pc;
  logic        o_illegal;

  exu_csr dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_csrid(i_csrid), .i_csrsren(i_csrsren), .i_csrdwen(i_csrdwen),
    .i_excsropt(i_excsropt), .i_excsrsrc(i_excsrsrc), .i_rs1val(i_rs1val),
    .i_imm(i_imm), .i_rdid(i_rdid), .i_rdwen(i_rdwen), .i_ecall(i_ecall),
    .i_mret(i_mret), .i_pc(i_pc), .o_valid(o_valid), .i_ready(i_ready),
    .o_rdid(o_rdid), .o_rdwen(o_rdwen), .o_rdwdata(o_rdwdata),
    .o_redirect(o_redirect), .o_redirect_pc(o_redirect_pc), .o_illegal(o_illegal)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: CSR contents as architecturally visible values
  logic [63:0] m_mstatus, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mcycle;
  logic        e_valid, e_rdwen, e_redirect, e_illegal;
  logic [4:0]  e_rdid;
  logic [63:0] e_rdwdata, e_rpc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit implemented(input logic [11:0] a);
    return a == 12'h300 || a == 12'h305 || a == 12'h340 ||
           a == 12'h341 || a == 12'h342 || a == 12'hB00;
  endfunction

  function automatic logic [63:0] csr_read(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'hB00: return m_mcycle;
      default: return 64'h0;
    endcase
  endfunction

  task automatic csr_write(input logic [11:0] a, input logic [63:0] v);
    case (a)
      12'h300: m_mstatus  = 64'h1800 | (v & 64'h88);
      12'h305: m_mtvec    = v & ~64'h3;
      12'h340: m_mscratch = v;
      12'h341: m_mepc     = v & ~64'h3;
      12'h342: m_mcause   = v;
      12'hB00: m_mcycle   = v;
      default: ;
    endcase
  endtask

  // Advance the model by one clock edge using the currently driven inputs
  task automatic model_step();
    logic [63:0] old_v, src, nv;
    bit hit, acc, cyc_loaded;
    cyc_loaded = 0;
    if (i_rst) begin
      m_mstatus = 64'h1800; m_mtvec = 64'h8000_0000; m_mscratch = 0;
      m_mepc = 0; m_mcause = 0; m_mcycle = 0;
      e_valid = 0; e_rdwen = 0; e_redirect = 0; e_illegal = 0;
      e_rdid = 0; e_rdwdata = 0; e_rpc = 0;
      return;
    end
    acc = i_valid && (!e_valid || i_ready);
    if (acc) begin
      hit   = implemented(i_csrid);
      old_v = csr_read(i_csrid);
      src   = i_excsrsrc ? i_imm : i_rs1val;
      case (i_excsropt)
        2'b01:   nv = src;
        2'b10:   nv = old_v | src;
        2'b11:   nv = old_v & ~src;
        default: nv = old_v;
      endcase
      e_valid = 1; e_rdid = i_rdid;
      if ((i_csrsren || i_csrdwen) && !hit) begin
        e_illegal = 1; e_rdwen = 0; e_rdwdata = 0;
      end else begin
        e_illegal = 0; e_rdwen = i_rdwen; e_rdwdata = i_csrsren ? old_v : 64'h0;
      end
      e_redirect = 0; e_rpc = 0;
      if (i_ecall) begin
        e_redirect = 1; e_rpc = m_mtvec;
        m_mepc = i_pc & ~64'h3; m_mcause = 11;
        m_mstatus = 64'h1800 | (m_mstatus[3] ? 64'h80 : 64'h0);
      end else if (i_mret) begin
        e_redirect = 1; e_rpc = m_mepc;
        m_mstatus = 64'h1880 | (m_mstatus[7] ? 64'h8 : 64'h0);
      end else if (i_csrdwen && i_excsropt != 2'b00 && hit) begin
        csr_write(i_csrid, nv);
        cyc_loaded = (i_csrid == 12'hB00);
      end
    end else if (e_valid && i_ready) begin
      e_valid = 0; e_redirect = 0; e_illegal = 0; e_rpc = 0;
    end
    if (!cyc_loaded) m_mcycle = m_mcycle + 64'd1;
  endtask

  task automatic step();
    #1;
    chk("o_ready", {63'b0, o_ready}, {63'b0, !e_valid || i_ready});
    model_step();
    @(posedge clk);
    #1;
    chk("o_valid", {63'b0, o_valid}, {63'b0, e_valid});
    chk("o_redirect", {63'b0, o_redirect}, {63'b0, e_redirect});
    chk("o_redirect_pc", o_redirect_pc, e_rpc);
    chk("o_illegal", {63'b0, o_illegal}, {63'b0, e_illegal});
    if (e_valid) begin
      chk("o_rdid", {59'b0, o_rdid}, {59'b0, e_rdid});
      chk("o_rdwen", {63'b0, o_rdwen}, {63'b0, e_rdwen});
      chk("o_rdwdata", o_rdwdata, e_rdwdata);
    end
  endtask

  task automatic csr_op(input logic [11:0] id, input bit sren, input bit dwen,
                        input logic [1:0] opt, input bit use_imm, input logic [63:0] val,
                        input logic [4:0] rd, input bit rdwen);
    i_valid = 1; i_csrid = id; i_csrsren = sren; i_csrdwen = dwen;
    i_excsropt = opt; i_excsrsrc = use_imm;
    i_imm    = use_imm ? val : {$urandom, $urandom};
    i_rs1val = use_imm ? {$urandom, $urandom} : val;
    i_rdid = rd; i_rdwen = rdwen; i_ecall = 0; i_mret = 0; i_pc = {$urandom, $urandom};
  endtask

  task automatic trap_op(input bit ecall, input bit mret, input logic [63:0] pc);
    i_valid = 1; i_csrid = 12'h000; i_csrsren = 0; i_csrdwen = 0; i_excsropt = 0;
    i_rdid = 0; i_rdwen = 0; i_ecall = ecall; i_mret = mret; i_pc = pc;
  endtask

  task automatic csr_rd(input logic [11:0] id);
    csr_op(id, 1, 0, 2'b10, 0, 64'h0, 5'd1, 1);
  endtask

  logic [63:0] held_data;
  logic [4:0]  held_rd;

  initial begin
    // Reset and reset values
    step(); step();
    i_rst = 0;
    csr_rd(12'h300); step(); chk("rst_mstatus", o_rdwdata, 64'h1800);
    csr_rd(12'h305); step(); chk("rst_mtvec", o_rdwdata, 64'h8000_0000);

    // csrrw mscratch
    csr_op(12'h340, 0, 1, 2'b01, 0, 64'h11, 5'd0, 0); step();
    csr_op(12'h340, 1, 1, 2'b01, 0, 64'hAA, 5'd5, 1); step();
    chk("rw_old", o_rdwdata, 64'h11); chk("rw_rdwen", {63'b0, o_rdwen}, 64'h1);
    chk("rw_rdid", {59'b0, o_rdid}, 64'd5);
    csr_rd(12'h340); step(); chk("rw_new", o_rdwdata, 64'hAA);

    // csrrsi / csrrc on MIE
    csr_op(12'h300, 1, 1, 2'b10, 1, 64'h8, 5'd3, 1); step();
    chk("rsi_old", o_rdwdata, 64'h1800);
    csr_op(12'h300, 1, 1, 2'b11, 0, 64'h8, 5'd3, 1); step();
    chk("rc_old", o_rdwdata, 64'h1808);
    csr_rd(12'h300); step(); chk("rc_new", o_rdwdata, 64'h1800);

    // ecall then mret
    csr_op(12'h305, 0, 1, 2'b01, 0, 64'h8000_1000, 5'd0, 0); step();
    csr_op(12'h300, 0, 1, 2'b10, 1, 64'h8, 5'd0, 0); step();
    trap_op(1, 0, 64'h8000_0010); step();
    chk("ecall_redir", {63'b0, o_redirect}, 64'h1);
    chk("ecall_pc", o_redirect_pc, 64'h8000_1000);
    csr_rd(12'h341); step(); chk("ecall_mepc", o_rdwdata, 64'h8000_0010);
    csr_rd(12'h342); step(); chk("ecall_mcause", o_rdwdata, 64'd11);
    chk("redir_clear", {63'b0, o_redirect}, 64'h0);
    trap_op(0, 1, 64'h1234); step();
    chk("mret_pc", o_redirect_pc, 64'h8000_0010);
    csr_rd(12'h300); step(); chk("mret_mstatus", o_rdwdata, 64'h1888);
    trap_op(1, 1, 64'h8000_0020); step();
    chk("both_pc", o_redirect_pc, 64'h8000_1000);

    // Back-pressure hold
    csr_op(12'h342, 1, 0, 2'b10, 0, 64'h0, 5'd7, 1); step();
    held_data = o_rdwdata; held_rd = o_rdid;
    chk("held_val", held_data, 64'd11);
    i_ready = 0;
    csr_op(12'h340, 1, 1, 2'b01, 0, 64'h33, 5'd9, 1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("hold_ready", {63'b0, o_ready}, 64'h0);
      chk("hold_data", o_rdwdata, held_data);
      chk("hold_rdid", {59'b0, o_rdid}, {59'b0, held_rd});
    end
    i_ready = 1; step();
    chk("rel_data", o_rdwdata, 64'hAA); chk("rel_rdid", {59'b0, o_rdid}, 64'd9);

    // Unimplemented address
    csr_op(12'h7C0, 1, 1, 2'b01, 0, 64'h55, 5'd4, 1); step();
    chk("ill_flag", {63'b0, o_illegal}, 64'h1);
    chk("ill_rdwen", {63'b0, o_rdwen}, 64'h0);
    chk("ill_data", o_rdwdata, 64'h0);
    csr_rd(12'h340); step(); chk("ill_nochg", o_rdwdata, 64'h33);

    // mcycle wrap
    csr_op(12'hB00, 0, 1, 2'b01, 0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0, 0); step();
    csr_rd(12'hB00); step(); chk("mcyc_max", o_rdwdata, 64'hFFFF_FFFF_FFFF_FFFF);
    csr_rd(12'hB00); step(); chk("mcyc_wrap", o_rdwdata, 64'h0);

    // Reset during a stall drops the held result
    csr_rd(12'h340); step();
    i_ready = 0; step();
    i_rst = 1; step();
    chk("rst_stall", {63'b0, o_valid}, 64'h0);
    i_rst = 0; i_ready = 1; i_valid = 0; step();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic [11:0] id;
      case ($urandom_range(0, 7))
        0: id = 12'h300; 1: id = 12'h305; 2: id = 12'h340; 3: id = 12'h341;
        4: id = 12'h342; 5: id = 12'hB00; 6: id = 12'h7C0;
        default: id = 12'($urandom);
      endcase
      csr_op(id, 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
             {$urandom, $urandom}, 5'($urandom), 1'($urandom));
      i_valid = ($urandom_range(0, 9) < 7);
      i_ready = ($urandom_range(0, 9) < 7);
      i_ecall = ($urandom_range(0, 15) == 0);
      i_mret  = ($urandom_range(0, 15) == 0);
      i_rst   = ($urandom_range(0, 49) == 0);
      step();
    end
    i_rst = 0; i_valid = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
